// File: rtl/bus_fabric_if.sv
// Data-side bus bundle between the core, the fabric and its slave ports.
// "slave" is the fabric's view; "master" is the core-plus-devices view.
interface bus_fabric_if #(
    parameter int N_SLAVES = 8
);
    logic [31:0]            m_addr;
    logic                   m_ren;
    logic                   m_wen;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic [31:0]            m_rdata;
    logic                   m_ready;
    logic                   m_err;

    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [N_SLAVES-1:0]    s_ren;
    logic [N_SLAVES-1:0]    s_wen;
    logic [N_SLAVES*32-1:0] s_rdata;
    logic [N_SLAVES-1:0]    s_ready;

    modport master (
        output m_addr, m_ren, m_wen, m_wdata, m_wstrb,
        input  m_rdata, m_ready, m_err,
        input  s_addr, s_wdata, s_wstrb, s_ren, s_wen,
        output s_rdata, s_ready
    );

    modport slave (
        input  m_addr, m_ren, m_wen, m_wdata, m_wstrb,
        output m_rdata, m_ready, m_err,
        output s_addr, s_wdata, s_wstrb, s_ren, s_wen,
        input  s_rdata, s_ready
    );
endinterface

// File: rtl/bus_fabric.sv
// Registered single-master data-bus fabric: base/mask decode, default slave,
// ready/wait-state handshake, decode-error and per-access timeout responses.
module bus_fabric #(
    parameter int                     N_SLAVES      = 8,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE    = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK    = {N_SLAVES{32'hFFFF_FFFF}},
    parameter int                     DEFAULT_SLAVE = 0,
    parameter int                     TIMEOUT       = 255,
    parameter int                     TO_W          = 8
) (
    input  logic         clk,
    input  logic         resetn,
    bus_fabric_if.slave  bus
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam bit HAS_DEFAULT = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < N_SLAVES);
    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(HAS_DEFAULT ? DEFAULT_SLAVE : 0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic             wr_q;
    logic [TO_W-1:0]  cnt_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [IDX_W-1:0]    dec_idx;
    logic [N_SLAVES-1:0] dec_onehot;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = N_SLAVES; i > 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[32*(i-1) +: 32]) ==
                (SLAVE_BASE[32*(i-1) +: 32] & SLAVE_MASK[32*(i-1) +: 32])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i - 1);
            end
        end
    end

    assign dec_idx    = hit ? hit_idx : DEF_IDX;
    assign dec_onehot = N_SLAVES'(1) << dec_idx;
    assign sel_ready  = bus.s_ready[idx_q];
    assign sel_rdata  = bus.s_rdata[32*idx_q +: 32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            bus.m_rdata <= '0;
            bus.m_ready <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wstrb <= '0;
            bus.s_ren   <= '0;
            bus.s_wen   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.m_ready <= 1'b0;
                    cnt_q       <= '0;
                    if (bus.m_ren || bus.m_wen) begin
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        bus.s_wstrb <= bus.m_wstrb;
                        wr_q        <= bus.m_wen;
                        idx_q       <= dec_idx;
                        if ((bus.m_ren && bus.m_wen) || !(hit || HAS_DEFAULT)) begin
                            bus.m_rdata <= '0;
                            bus.m_err   <= 1'b1;
                            bus.m_ready <= 1'b1;
                            state       <= RESP;
                        end else begin
                            if (bus.m_wen) begin
                                bus.s_wen <= dec_onehot;
                            end else begin
                                bus.s_ren <= dec_onehot;
                            end
                            state <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (sel_ready) begin
                        bus.m_rdata <= wr_q ? '0 : sel_rdata;
                        bus.m_err   <= 1'b0;
                        bus.m_ready <= 1'b1;
                        bus.s_ren   <= '0;
                        bus.s_wen   <= '0;
                        state       <= RESP;
                    end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        bus.m_rdata <= 32'hDEAD_BEEF;
                        bus.m_err   <= 1'b1;
                        bus.m_ready <= 1'b1;
                        bus.s_ren   <= '0;
                        bus.s_wen   <= '0;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    bus.m_ready <= 1'b0;
                    cnt_q       <= '0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
